// File: rtl/alu_seq_defs_pkg.sv
// Shared definitions for the byte-serial ALU sequencer.
// Holds the op and state encodings and the slice width.
package alu_seq_defs;

  localparam int SLICE_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic logic is_arith(input alu_op_t op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/cla_8.sv
// 8-bit carry-lookahead slice: sum, group generate/propagate, bitwise AND/OR and zero detect.
module cla_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       g,
  output logic       p,
  output logic [7:0] bw_and,
  output logic [7:0] bw_or,
  output logic       is_zero
);
  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [8:0] c_s;

  // Lookahead carries and group terms, flattened by synthesis.
  always_comb begin
    gen_s  = a & b;
    prop_s = a ^ b;
    c_s    = 9'd0;
    c_s[0] = cin;
    g      = 1'b0;
    p      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_s[i+1] = gen_s[i] | (prop_s[i] & c_s[i]);
      g        = gen_s[i] | (prop_s[i] & g);
      p        = p & prop_s[i];
    end
    s       = prop_s ^ c_s[7:0];
    bw_and  = a & b;
    bw_or   = a | b;
    is_zero = (s == 8'd0);
  end

endmodule

// File: rtl/cla_slice_sequencer.sv
// 32-bit ADD/SUB/AND/OR computed one byte per cycle through a single cla_8 slice.
// Optional macro SEQ_FAST_LOGIC_EN: AND/OR complete in the accepting cycle.
module cla_slice_sequencer
  import alu_seq_defs::*;
#(
  parameter int NUM_SLICES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [1:0]                    ctrl_op,
  input  logic [SLICE_W*NUM_SLICES-1:0] data_operandA,
  input  logic [SLICE_W*NUM_SLICES-1:0] data_operandB,
  output logic                          ready,
  output logic                          result_valid,
  output logic [SLICE_W*NUM_SLICES-1:0] data_result,
  output logic                          isZero,
  output logic                          carry_out,
  output logic                          overflow
);
  localparam int W = SLICE_W * NUM_SLICES;
  localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  seq_state_t         state_r;
  alu_op_t            op_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       shadow_r;
  logic [W-1:0]       shadow_next_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic               zero_r;
  logic [SLICE_W-1:0] a_byte_s;
  logic [SLICE_W-1:0] b_byte_s;
  logic [SLICE_W-1:0] sum_s;
  logic [SLICE_W-1:0] and_s;
  logic [SLICE_W-1:0] or_s;
  logic [SLICE_W-1:0] byte_res_s;
  logic               g_s;
  logic               p_s;
  logic               slice_zero_s;
  logic               slice_cout_s;
  logic               byte_zero_s;

  cla_8 u_slice (
    .a       (a_byte_s),
    .b       (b_byte_s),
    .cin     (carry_r),
    .s       (sum_s),
    .g       (g_s),
    .p       (p_s),
    .bw_and  (and_s),
    .bw_or   (or_s),
    .is_zero (slice_zero_s)
  );

  // Byte select into the slice and byte insert into the shadow result.
  always_comb begin
    a_byte_s     = a_r[int'(idx_r)*SLICE_W +: SLICE_W];
    b_byte_s     = b_r[int'(idx_r)*SLICE_W +: SLICE_W];
    slice_cout_s = g_s | (p_s & carry_r);
    case (op_r)
      OP_AND: begin
        byte_res_s  = and_s;
        byte_zero_s = (and_s == {SLICE_W{1'b0}});
      end
      OP_OR: begin
        byte_res_s  = or_s;
        byte_zero_s = (or_s == {SLICE_W{1'b0}});
      end
      default: begin
        byte_res_s  = sum_s;
        byte_zero_s = slice_zero_s;
      end
    endcase
    shadow_next_s = shadow_r;
    shadow_next_s[int'(idx_r)*SLICE_W +: SLICE_W] = byte_res_s;
  end

`ifdef SEQ_FAST_LOGIC_EN
  logic [W-1:0] fast_res_s;
  logic         fast_op_s;

  // Full-width logic result straight from the operand ports.
  always_comb begin
    fast_op_s = (ctrl_op == OP_AND) || (ctrl_op == OP_OR);
    if (ctrl_op == OP_AND) begin
      fast_res_s = data_operandA & data_operandB;
    end else begin
      fast_res_s = data_operandA | data_operandB;
    end
  end
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_ADD;
      a_r          <= {W{1'b0}};
      b_r          <= {W{1'b0}};
      shadow_r     <= {W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      carry_r      <= 1'b0;
      zero_r       <= 1'b0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      data_result  <= {W{1'b0}};
      isZero       <= 1'b0;
      carry_out    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            op_r     <= alu_op_t'(ctrl_op);
            a_r      <= data_operandA;
            shadow_r <= {W{1'b0}};
            idx_r    <= {IDX_W{1'b0}};
            zero_r   <= 1'b1;
            ready    <= 1'b0;
            // Subtraction runs as A + ~B + 1.
            if (ctrl_op == OP_SUB) begin
              b_r     <= ~data_operandB;
              carry_r <= 1'b1;
            end else begin
              b_r     <= data_operandB;
              carry_r <= 1'b0;
            end
`ifdef SEQ_FAST_LOGIC_EN
            if (fast_op_s) begin
              state_r      <= ST_DONE;
              result_valid <= 1'b1;
              data_result  <= fast_res_s;
              isZero       <= (fast_res_s == {W{1'b0}});
              carry_out    <= 1'b0;
              overflow     <= 1'b0;
            end else begin
              state_r <= ST_RUN;
            end
`else
            state_r <= ST_RUN;
`endif
          end
        end
        ST_RUN: begin
          shadow_r <= shadow_next_s;
          carry_r  <= slice_cout_s;
          zero_r   <= zero_r & byte_zero_s;
          idx_r    <= idx_r + IDX_W'(1);
          if (idx_r == LAST_IDX) begin
            state_r      <= ST_DONE;
            result_valid <= 1'b1;
            data_result  <= shadow_next_s;
            isZero       <= zero_r & byte_zero_s;
            if (is_arith(op_r)) begin
              carry_out <= slice_cout_s;
              overflow  <= (a_r[W-1] == b_r[W-1]) & (shadow_next_s[W-1] != a_r[W-1]);
            end else begin
              carry_out <= 1'b0;
              overflow  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          ready        <= 1'b1;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Self-checking bench for cla_slice_sequencer: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_cla_slice_sequencer;
  localparam int NSL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  ctrl_op = 2'b00;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ready;
  logic        result_valid;
  logic [31:0] data_result;
  logic        isZero;
  logic        carry_out;
  logic        overflow;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] prev_res = 32'd0;

  cla_slice_sequencer #(.NUM_SLICES(NSL)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .ctrl_op       (ctrl_op),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ready         (ready),
    .result_valid  (result_valid),
    .data_result   (data_result),
    .isZero        (isZero),
    .carry_out     (carry_out),
    .overflow      (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: true integer arithmetic; overflow when the 32-bit result differs from the exact signed value.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic o);
    longint sa;
    longint sb;
    longint exact;
    logic [32:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0;
    c = 1'b0;
    o = 1'b0;
    case (op)
      2'b00: begin
        wide  = {1'b0, a} + {1'b0, b};
        r     = wide[31:0];
        c     = wide[32];
        exact = sa + sb;
        o     = (exact != longint'($signed(r)));
      end
      2'b01: begin
        r     = a - b;
        c     = (a >= b);
        exact = sa - sb;
        o     = (exact != longint'($signed(r)));
      end
      2'b10: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  // One operation from a negedge with ready=1; ends on a negedge with ready=1 again.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [31:0] er;
    logic        ec;
    logic        eo;
    int          lat;
    int          exp_lat;
    bit          seen;
    model(op, a, b, er, ec, eo);
`ifdef SEQ_FAST_LOGIC_EN
    exp_lat = op[1] ? 1 : NSL + 1;
`else
    exp_lat = NSL + 1;
`endif
    start = 1'b1;
    ctrl_op = op;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    start = 1'b0;
    ctrl_op = 2'($urandom_range(0, 3));
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clock);
      lat++;
      if (result_valid) begin
        seen = 1'b1;
      end else begin
        if (lat == 1) check("hold_prev", data_result, prev_res);
        if (inject && lat == 2) begin
          start = 1'b1;
          ctrl_op = 2'b01;
          data_operandA = $urandom;
          data_operandB = $urandom;
        end
        if (inject && lat == 3) start = 1'b0;
      end
    end
    check("valid_seen", 32'(seen), 32'd1);
    check("latency", lat, exp_lat);
    check("result", data_result, er);
    check("carry_out", 32'(carry_out), 32'(ec));
    check("overflow", 32'(overflow), 32'(eo));
    check("isZero", 32'(isZero), 32'(er == 32'd0));
    check("busy_at_valid", 32'(ready), 32'd0);
    @(negedge clock);
    check("valid_pulse", 32'(result_valid), 32'd0);
    check("ready_back", 32'(ready), 32'd1);
    check("result_hold", data_result, er);
    prev_res = er;
    if (inject) begin
      @(negedge clock);
      check("no_queued_op", 32'(result_valid), 32'd0);
      check("still_ready", 32'(ready), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          vcount;

    repeat (2) @(negedge clock);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_result", data_result, 32'd0);
    check("rst_flags", {29'd0, isZero, carry_out, overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    do_op(2'b00, 32'h000000FF, 32'h00000001, 1'b0);
    do_op(2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0);
    do_op(2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    do_op(2'b01, 32'h00000005, 32'h00000005, 1'b0);
    do_op(2'b01, 32'h80000000, 32'h00000001, 1'b0);
    do_op(2'b10, 32'hF0F0A5A5, 32'hFF00FF00, 1'b0);
    do_op(2'b11, 32'hF0F0A5A5, 32'hFF00FF00, 1'b0);
    do_op(2'b00, 32'h12345678, 32'h11111111, 1'b1);

    // Abort an ADD with reset two cycles after acceptance.
    start = 1'b1;
    ctrl_op = 2'b00;
    data_operandA = 32'h00001234;
    data_operandB = 32'h00005678;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_result", data_result, 32'd0);
    check("abort_flags", {29'd0, isZero, carry_out, overflow}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    vcount = 0;
    repeat (8) begin
      @(negedge clock);
      if (result_valid) vcount++;
    end
    check("abort_no_valid", vcount, 32'd0);
    prev_res = 32'd0;
    do_op(2'b00, 32'd3, 32'd4, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      do_op(2'($urandom_range(0, 3)), ra, rb, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
